// File: rtl/pistache_ctrl_pkg.sv
// Shared control definitions for the pistache RV32I pipeline: opcode
// constants, the hazard sequencer state encoding and an rs2-usage helper.
package pistache_ctrl_pkg;

  localparam logic [6:0] OPC_R    = 7'b0110011;
  localparam logic [6:0] OPC_I    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD = 7'b0000011;
  localparam logic [6:0] OPC_S    = 7'b0100011;
  localparam logic [6:0] OPC_B    = 7'b1100011;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    ERROR    = 2'd3
  } seq_state_e;

  // Only these formats carry a real rs2; elsewhere bits [24:20] are immediate.
  function automatic logic uses_rs2(input logic [6:0] opc);
    return (opc == OPC_R) || (opc == OPC_S) || (opc == OPC_B);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_sequencer.sv
// Hazard/stall sequencer: boot bubbles, load-use stall, branch flush,
// data-memory freeze with timeout, and saturating stall/flush statistics.
module hazard_sequencer
  import pistache_ctrl_pkg::*;
#(
  parameter int BOOT_CYCLES = 2,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      id_inst_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_memread_i,
  input  logic             br_taken_i,
  input  logic             mem_access_i,
  input  logic             dmem_ready_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             pipe_en_o,
  output logic             nop_o,
  output logic             flush_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam int WW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  seq_state_e    state_q, state_d;
  logic [BW-1:0] boot_cnt_q, boot_cnt_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic          err_q, err_d;
  logic          freeze, run_eval, load_use;
  logic          unused_inst_bits;

  assign unused_inst_bits = ^{id_inst_i[31:25], id_inst_i[14:7]};

  assign load_use = ex_memread_i && (ex_rd_i != 5'd0) &&
                    ((ex_rd_i == id_inst_i[19:15]) ||
                     (uses_rs2(id_inst_i[6:0]) && (ex_rd_i == id_inst_i[24:20])));

  // Memory handshake: mem_access_i marks a MEM-stage access, dmem_ready_i is
  // a completion strobe; until it is seen the whole pipeline holds still.
  always_comb begin
    state_d      = state_q;
    boot_cnt_d   = boot_cnt_q;
    wait_cnt_d   = '0;
    err_d        = err_q;
    freeze       = 1'b0;
    run_eval     = 1'b0;
    pc_write_o   = 1'b0;
    ifid_write_o = 1'b0;
    pipe_en_o    = 1'b0;
    nop_o        = 1'b0;
    flush_o      = 1'b0;

    case (state_q)
      BOOT: begin
        pipe_en_o = 1'b1;
        nop_o     = 1'b1;
        if (boot_cnt_q == BW'(BOOT_CYCLES - 1)) begin
          state_d = RUN;
        end else begin
          boot_cnt_d = boot_cnt_q + BW'(1);
        end
      end
      RUN: begin
        if (mem_access_i && !dmem_ready_i) begin
          freeze  = 1'b1;
          state_d = MEM_WAIT;
        end else begin
          run_eval = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!dmem_ready_i) begin
          freeze = 1'b1;
        end else begin
          run_eval = 1'b1;
          state_d  = RUN;
        end
      end
      ERROR: begin
        nop_o = 1'b1;
      end
      default: state_d = BOOT;
    endcase

    // Freeze outputs are the all-zero defaults; only the timer moves.
    if (freeze) begin
      wait_cnt_d = wait_cnt_q + WW'(1);
      if (wait_cnt_q == WW'(MEM_TIMEOUT - 1)) begin
        state_d = ERROR;
      end
    end

    if (run_eval) begin
      pipe_en_o = 1'b1;
      if (br_taken_i) begin
        flush_o      = 1'b1;
        pc_write_o   = 1'b1;
        ifid_write_o = 1'b1;
      end else if (load_use) begin
        nop_o = 1'b1;
      end else begin
        pc_write_o   = 1'b1;
        ifid_write_o = 1'b1;
      end
    end

    if (state_d == ERROR) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= BOOT;
      boot_cnt_q <= '0;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  assign err_o = err_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .inc_i (((state_q == RUN) || (state_q == MEM_WAIT)) && !pc_write_o),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .inc_i (flush_o),
    .cnt_o (flush_cnt_o)
  );

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer: per-cycle stimulus/expected-output
// vectors with hand-computed values, plus counter and error checks.
module tb_hazard_sequencer;

  localparam int CNT_W = 4;

  // {pc_write, ifid_write, pipe_en, nop, flush, err}
  localparam logic [5:0] P_BOOT  = 6'b001100;
  localparam logic [5:0] P_RUN   = 6'b111000;
  localparam logic [5:0] P_STALL = 6'b001100;
  localparam logic [5:0] P_FLUSH = 6'b111010;
  localparam logic [5:0] P_FRZ   = 6'b000000;
  localparam logic [5:0] P_ERR   = 6'b000101;

  localparam logic [31:0] ADD_X6_X5_X7 = 32'h00728333;
  localparam logic [31:0] ADDI_X6_X7_5 = 32'h00538313;

  logic             clk = 1'b0;
  logic             rst_i = 1'b1;
  logic [31:0]      id_inst_i = '0;
  logic [4:0]       ex_rd_i = '0;
  logic             ex_memread_i = 1'b0;
  logic             br_taken_i = 1'b0;
  logic             mem_access_i = 1'b0;
  logic             dmem_ready_i = 1'b0;
  logic             pc_write_o, ifid_write_o, pipe_en_o, nop_o, flush_o, err_o;
  logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;

  typedef struct packed {
    logic        ma;
    logic        dr;
    logic        br;
    logic        mr;
    logic [4:0]  rd;
    logic [31:0] inst;
  } stim_t;

  stim_t      stim_q[$];
  logic [5:0] exp_q[$];
  int         n_checks = 0;
  int         n_fail = 0;

  hazard_sequencer #(
    .BOOT_CYCLES (2),
    .MEM_TIMEOUT (4),
    .CNT_W       (CNT_W)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .id_inst_i    (id_inst_i),
    .ex_rd_i      (ex_rd_i),
    .ex_memread_i (ex_memread_i),
    .br_taken_i   (br_taken_i),
    .mem_access_i (mem_access_i),
    .dmem_ready_i (dmem_ready_i),
    .pc_write_o   (pc_write_o),
    .ifid_write_o (ifid_write_o),
    .pipe_en_o    (pipe_en_o),
    .nop_o        (nop_o),
    .flush_o      (flush_o),
    .err_o        (err_o),
    .stall_cnt_o  (stall_cnt_o),
    .flush_cnt_o  (flush_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic vec(input logic ma, input logic dr, input logic br, input logic mr,
                     input logic [4:0] rd, input logic [31:0] inst, input logic [5:0] exp);
    stim_t s;
    s.ma = ma; s.dr = dr; s.br = br; s.mr = mr; s.rd = rd; s.inst = inst;
    stim_q.push_back(s);
    exp_q.push_back(exp);
  endtask

  task automatic idle(input logic [5:0] exp);
    vec(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, exp);
  endtask

  // Drives each queued vector for one cycle and checks the Mealy outputs.
  task automatic run(input string tag);
    stim_t      s;
    logic [5:0] e;
    int         idx;
    idx = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      mem_access_i = s.ma;
      dmem_ready_i = s.dr;
      br_taken_i   = s.br;
      ex_memread_i = s.mr;
      ex_rd_i      = s.rd;
      id_inst_i    = s.inst;
      #1;
      check($sformatf("%s[%0d]", tag, idx),
            {26'd0, pc_write_o, ifid_write_o, pipe_en_o, nop_o, flush_o, err_o}, {26'd0, e});
      idx++;
      @(negedge clk);
    end
  endtask

  task automatic check_cnts(input string tag, input int stall, input int flush);
    check({tag, "_stall_cnt"}, 32'(stall_cnt_o), stall);
    check({tag, "_flush_cnt"}, 32'(flush_cnt_o), flush);
  endtask

  initial begin
    rst_i = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs",
          {26'd0, pc_write_o, ifid_write_o, pipe_en_o, nop_o, flush_o, err_o}, {26'd0, P_BOOT});
    check_cnts("reset", 0, 0);
    rst_i = 1'b0;

    idle(P_BOOT); idle(P_BOOT); idle(P_RUN);
    run("boot");
    check_cnts("boot", 0, 0);

    vec(1'b0, 1'b0, 1'b0, 1'b1, 5'd5, ADD_X6_X5_X7, P_STALL);
    idle(P_RUN);
    run("load_use_rs1");
    check_cnts("load_use_rs1", 1, 0);

    vec(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, ADD_X6_X5_X7, P_RUN);
    vec(1'b0, 1'b0, 1'b0, 1'b1, 5'd5, ADDI_X6_X7_5, P_RUN);
    vec(1'b0, 1'b0, 1'b0, 1'b1, 5'd7, ADD_X6_X5_X7, P_STALL);
    vec(1'b0, 1'b0, 1'b0, 1'b1, 5'd7, ADDI_X6_X7_5, P_STALL);
    vec(1'b0, 1'b0, 1'b0, 1'b0, 5'd5, ADD_X6_X5_X7, P_RUN);
    run("load_use_mix");
    check_cnts("load_use_mix", 3, 0);

    vec(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, P_FLUSH);
    idle(P_RUN);
    vec(1'b0, 1'b0, 1'b1, 1'b1, 5'd5, ADD_X6_X5_X7, P_FLUSH);
    idle(P_RUN);
    run("branch");
    check_cnts("branch", 3, 2);

    repeat (3) vec(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, P_FRZ);
    vec(1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, P_FLUSH);
    idle(P_RUN);
    run("mem_wait_branch");
    check_cnts("mem_wait_branch", 6, 3);

    repeat (14) vec(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, P_FLUSH);
    idle(P_RUN);
    run("flush_saturate");
    check_cnts("flush_saturate", 6, 15);

    repeat (4) vec(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, P_FRZ);
    vec(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, P_ERR);
    vec(1'b0, 1'b1, 1'b1, 1'b1, 5'd5, ADD_X6_X5_X7, P_ERR);
    vec(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, P_ERR);
    run("timeout");
    check_cnts("timeout", 10, 15);

    rst_i = 1'b1;
    mem_access_i = 1'b0; dmem_ready_i = 1'b0; br_taken_i = 1'b0;
    ex_memread_i = 1'b0; ex_rd_i = '0; id_inst_i = '0;
    @(negedge clk);
    rst_i = 1'b0;
    idle(P_BOOT); idle(P_BOOT); idle(P_RUN);
    run("reset_from_error");
    check_cnts("reset_from_error", 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_sequencer.md
# hazard_sequencer

Pipeline hazard and stall sequencer for the πStache RV32I five-stage core. It watches the instruction in IF/ID, the EX-stage load destination, the EX branch resolution and the data-memory handshake. From these it drives PC/IF-ID write enables, the pipeline-register enable, flush, and the `nop_i` input of `ControlUnit`. It also owns the post-reset boot bubbles, the memory-wait timeout and saturating stall/flush statistics.

## Interface
- `BOOT_CYCLES`, default 2: bubble cycles after reset before fetch starts (≥1).
- `MEM_TIMEOUT`, default 255: consecutive not-ready memory cycles before the block declares an error (≥1).
- `CNT_W`, default 16: width of the statistics counters.

- `clk_i`  in  1  single clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `id_inst_i`  in  32  instruction currently in IF/ID.
- `ex_rd_i`  in  5  rd of the instruction in EX.
- `ex_memread_i`  in  1  instruction in EX is a load.
- `br_taken_i`  in  1  branch in EX resolved taken.
- `mem_access_i`  in  1  MEM stage holds a load or store.
- `dmem_ready_i`  in  1  data memory completes the access this cycle.
- `pc_write_o`  out  1  PC register write enable.
- `ifid_write_o`  out  1  IF/ID write enable.
- `pipe_en_o`  out  1  ID/EX, EX/MEM, MEM/WB enable.
- `nop_o`  out  1  to `ControlUnit` `nop_i`; forces a bubble into ID/EX.
- `flush_o`  out  1  clears IF/ID and ID/EX.
- `err_o`  out  1  sticky memory-timeout error.
- `stall_cnt_o`  out  CNT_W  saturating count of stall cycles.
- `flush_cnt_o`  out  CNT_W  saturating count of flush cycles.

## Operation
- States:
  - `BOOT`: reset state.
    - Outputs: pc_write=0, ifid_write=0, pipe_en=1, nop=1, flush=0.
    - `boot_cnt` counts up from 0; at `BOOT_CYCLES`-1 the next state is `RUN`.
  - `RUN`: outputs are evaluated in this priority order.
    1. Memory freeze (`mem_access_i` & !`dmem_ready_i`): pc_write=0, ifid_write=0, pipe_en=0, nop=0, flush=0. Next state is `MEM_WAIT`.
    2. Taken branch: flush=1, pc_write=1, ifid_write=1, pipe_en=1, nop=0.
    3. Load-use hazard: pc_write=0, ifid_write=0, pipe_en=1, nop=1.
    4. Otherwise: pc_write=1, ifid_write=1, pipe_en=1, nop=0, flush=0.
  - `MEM_WAIT`:
    - While !`dmem_ready_i`: freeze outputs as in `RUN` item 1.
    - On the cycle `dmem_ready_i`=1: evaluate exactly as `RUN` and return to `RUN`.
  - `ERROR`: pc_write=0, ifid_write=0, pipe_en=0, nop=1, flush=0, err=1. All inputs are ignored; only `rst_i` exits.
- Load-use hazard condition:
  - `ex_memread_i` is high and `ex_rd_i`≠0.
  - And `ex_rd_i` equals rs1 (`id_inst_i`[19:15]), or equals rs2 (`id_inst_i`[24:20]) when the opcode is R (0110011), S (0100011) or B (1100011).
  - The I-type rs2 field is never compared.
- Wait timer:
  - `wait_cnt` is cleared outside `MEM_WAIT` and increments on every freeze cycle.
  - A freeze cycle with `wait_cnt`=`MEM_TIMEOUT`-1 moves the next state to `ERROR`.
  - Result: `MEM_TIMEOUT` consecutive not-ready cycles lead to `ERROR`.
- Counters:
  - `stall_cnt` increments on each cycle with pc_write=0 in `RUN`/`MEM_WAIT`.
  - `flush_cnt` increments on each cycle with flush=1.
  - Both saturate at all-ones and never wrap.
- Simultaneous branch and memory freeze: the freeze wins. The branch stays held in EX and is flushed on the release cycle.
- Reset values: state=`BOOT`, `boot_cnt`=`wait_cnt`=0, err=0, both counters 0. The outputs therefore show the `BOOT` pattern.
- `rst_i` asserted in any state (including `MEM_WAIT`/`ERROR`) restores reset values at the next edge.

## Timing
- All control outputs are combinational (Mealy) from the current state and inputs: zero-cycle latency, so the hazard acts in the cycle it is detected.
- State, timers, `err_o` and the counters are registered.
- A load-use stall lasts exactly one cycle, because the bubble then occupies EX.
- A memory access not ready at cycle N and ready at N+k freezes cycles N..N+k-1 and releases at N+k. The state is `RUN` at N+k+1.
- After `rst_i` deasserts, the first pc_write=1 occurs `BOOT_CYCLES` cycles later.

## Structure
- Shared package `pistache_ctrl_pkg` holds:
  - the opcode constants (R, I, load, S, B);
  - the state enum (`BOOT`, `RUN`, `MEM_WAIT`, `ERROR`).
- One sub-module, `sat_counter` (parameter width, inputs `inc` and sync `clr`), is instantiated for both statistics counters.

## Test plan
- Reset with `BOOT_CYCLES`=2: `rst_i` high 3 cycles, then low -> nop=1, pc_write=0 for 2 cycles; the 3rd cycle gives pc_write=1, nop=0.
- Load-use positive case: `ex_memread_i`=1, `ex_rd_i`=5, `id_inst_i`=0x00728333 (add x6,x5,x7) -> one cycle of pc_write=0, ifid_write=0, nop=1, and `stall_cnt`+1.
- Load-use negative cases:
  - same inputs with `ex_rd_i`=0 -> no stall;
  - `id_inst_i`=0x00538313 (addi x6,x7,5) with `ex_rd_i`=5 -> no stall.
- `br_taken_i`=1 in `RUN` -> flush=1, pc_write=1 for that cycle, `flush_cnt` 0→1.
- Memory wait plus branch: `mem_access_i`=1, `dmem_ready_i`=0 for 3 cycles then 1, `br_taken_i`=1 throughout -> pipe_en=0, flush=0 for 3 cycles; the 4th cycle gives pipe_en=1, flush=1; `stall_cnt`+3.
- `MEM_TIMEOUT`=4, `dmem_ready_i` held 0 -> `err_o`=1 from cycle 5 onward. It stays high after `dmem_ready_i`=1 and clears only on `rst_i`.
